// File: rtl/idct2d_pkg.sv
// rtl/idct2d_pkg.sv - shared constants and types for the 8x8 IDCT scheduler
package idct2d_pkg;

  localparam int N     = 8;
  localparam int W_IN  = 16;
  localparam int W_OUT = 9;

  typedef logic       bank_t;
  typedef logic [2:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/idct2d_tbuf.sv
// rtl/idct2d_tbuf.sv - ping-pong transpose buffer, row-wise write port and column-wise read port
module idct2d_tbuf
  import idct2d_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en_i,
  input  bank_t             wr_bank_i,
  input  idx_t              wr_row_i,
  input  logic [N*W_IN-1:0] wr_data_i,
  input  bank_t             rd_bank_i,
  input  idx_t              rd_col_i,
  output logic [N*W_IN-1:0] rd_data_o
);

  // Indexed [bank][column][row]; contents are deliberately not reset.
  logic [W_IN-1:0] mem_q [2][N][N];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int j = 0; j < N; j++) begin
        mem_q[wr_bank_i][j][wr_row_i] <= wr_data_i[j*W_IN +: W_IN];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < N; r++) begin
      rd_data_o[r*W_IN +: W_IN] = mem_q[rd_bank_i][rd_col_i][r];
    end
  end

endmodule

// File: rtl/idct2d_sched.sv
// rtl/idct2d_sched.sv - row/column pass scheduler for the 2-D IDCT around external 1-D kernels
module idct2d_sched
  import idct2d_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W_IN-1:0]  in_data,
  output logic               rk_go,
  output logic [N*W_IN-1:0]  rk_a,
  input  logic [N*W_IN-1:0]  rk_b,
  output logic               ck_go,
  output logic [N*W_IN-1:0]  ck_a,
  input  logic [N*W_OUT-1:0] ck_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W_OUT-1:0] out_data,
  output logic [2:0]         out_col,
  output logic               out_last
);

  logic [1:0] full_q, full_d;
  bank_t      wbank_q, rbank_q;
  idx_t       wr_q, rc_q;
  rd_state_t  state_q;
  logic       out_valid_q;
  logic       in_accept, out_accept;

  // Gated by the reset pin so the writer reports not-ready for the whole reset interval.
  assign in_ready   = reset & ~full_q[wbank_q];
  assign in_accept  = in_valid & in_ready;
  assign out_accept = out_valid_q & out_ready;

  assign rk_go     = in_accept;
  assign rk_a      = in_data;
  assign out_valid = out_valid_q;
  assign ck_go     = out_valid_q;
  assign out_data  = ck_b;
  assign out_col   = rc_q;
  assign out_last  = out_valid_q & (rc_q == LAST_IDX);

  // Set and clear always hit different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (out_accept && rc_q == LAST_IDX) full_d[rbank_q] = 1'b0;
    if (in_accept && wr_q == LAST_IDX)  full_d[wbank_q] = 1'b1;
  end

  // Reader decisions look at full_d so column 0 follows the row-7 accept by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q      <= 2'b00;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wr_q        <= '0;
      rc_q        <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (in_accept) begin
        wr_q <= wr_q + 3'd1;
        if (wr_q == LAST_IDX) wbank_q <= ~wbank_q;
      end
      case (state_q)
        IDLE: begin
          if (full_d[rbank_q]) begin
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
            rc_q        <= '0;
          end
        end
        DRAIN: begin
          if (out_accept) begin
            rc_q <= rc_q + 3'd1;
            if (rc_q == LAST_IDX) begin
              rbank_q <= ~rbank_q;
              if (!full_d[~rbank_q]) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  idct2d_tbuf u_tbuf (
    .clock     (clock),
    .wr_en_i   (in_accept),
    .wr_bank_i (wbank_q),
    .wr_row_i  (wr_q),
    .wr_data_i (rk_b),
    .rd_bank_i (rbank_q),
    .rd_col_i  (rc_q),
    .rd_data_o (ck_a)
  );

endmodule
